// File: rtl/mul_add_seq.sv
// rtl/mul_add_seq.sv - sequential shift-and-add multiply-accumulate, p = a*b + r
// Optional MULADD_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_add_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     r,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   p
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [W-1:0]     mreg, mreg_nx, mreg_shift;
    logic [2*W-1:0]   mcand, mcand_nx;
    logic [2*W-1:0]   acc, acc_nx, acc_sum;
    logic [2*W-1:0]   p_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             last_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mreg  <= '0;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            state <= state_nx;
            mreg  <= mreg_nx;
            mcand <= mcand_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            p     <= p_nx;
        end
    end

    // The final partial product is folded in on the same edge that enters DONE,
    // so p is loaded from the adder output rather than from acc.
    assign acc_sum    = mreg[0] ? (acc + mcand) : acc;
    assign mreg_shift = mreg >> 1;

`ifdef MULADD_EARLY_EXIT_EN
    assign last_step = (cnt == CNT_LAST) || (mreg_shift == '0);
`else
    assign last_step = (cnt == CNT_LAST);
`endif

    always_comb begin
        state_nx = state;
        mreg_nx  = mreg;
        mcand_nx = mcand;
        acc_nx   = acc;
        cnt_nx   = cnt;
        p_nx     = p;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    mreg_nx  = a;
                    mcand_nx = {{W{1'b0}}, b};
                    acc_nx   = {{W{1'b0}}, r};
                    cnt_nx   = '0;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                acc_nx   = acc_sum;
                mcand_nx = mcand << 1;
                mreg_nx  = mreg_shift;
                cnt_nx   = cnt + CW'(1);
                if (last_step) begin
                    state_nx = DONE;
                    p_nx     = acc_sum;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_add_seq.sv
// tb/tb_mul_add_seq.sv - scoreboard bench for mul_add_seq against a*b+r and its latency rule
module tb_mul_add_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0, b = '0, r = '0;
    logic           busy, done;
    logic [2*W-1:0] p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [2*W-1:0] last_p = '0;

    typedef struct {
        int p;
        int cyc;
    } exp_t;
    exp_t sb[$];

    mul_add_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .r(r),
        .busy(busy), .done(done), .p(p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Number of RUN cycles an operation with multiplier x takes.
    function automatic int run_cycles(input int x);
`ifdef MULADD_EARLY_EXIT_EN
        int k;
        k = 1;
        for (int i = 0; i < W; i++)
            if ((x >> i) & 1) k = i + 1;
        return k;
`else
        return W;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                exp_t e;
                check("busy_with_done", int'(busy), 0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("p_value", int'(p), e.p);
                    check("done_cycle", cyc, e.cyc);
                end
                last_p = p;
            end else begin
                check("p_stable", int'(p), int'(last_p));
            end
        end
    end

    // Called at a negedge with busy low; returns at the negedge after acceptance.
    task automatic issue(input int ia, input int ib, input int ir);
        exp_t e;
        a = ia[W-1:0];
        b = ib[W-1:0];
        r = ir[W-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        e.p = ia * ib + ir;
        e.cyc = cyc + run_cycles(ia);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) return;
            @(negedge clk);
        end
        check("done_timeout", 0, 1);
    endtask

    initial begin
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_p", int'(p), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(3, 5, 2);
        check("busy_after_accept", int'(busy), 1);
        wait_done();
        check("p_3_5_2", int'(p), 17);
        issue(2, 7, 1);
        wait_done();
        check("p_2_7_1", int'(p), 15);
        issue(15, 15, 15);
        wait_done();
        check("p_max", int'(p), 240);
        issue(15, 1, 0);
        wait_done();
        issue(1, 9, 7);
        wait_done();
        check("p_1_9_7", int'(p), 16);
        issue(0, 9, 7);
        wait_done();
        check("p_0_9_7", int'(p), 7);

        // start while busy must be ignored
        issue(9, 3, 4);
        a = 4'd15; b = 4'd15; r = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("p_ignored_start", int'(p), 31);
        @(negedge clk);
        @(negedge clk);

        // mid-op reset
        issue(9, 9, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_p", int'(p), 0);
        sb.delete();
        last_p = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(9, 9, 0);
        wait_done();
        check("p_after_rst", int'(p), 81);

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ir = 0; ir < 16; ir++) begin
                    issue(ia, ib, ir);
                    wait_done();
                end

        for (int i = 0; i < 200; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
